// File: rtl/sysarr_host_seq_pkg.sv
// ---------------------------------------------------------------------------
// sysarr_host_seq_pkg
// Shared definitions for the systolic-array host sequencer:
//   - host command op codes
//   - sequencer state encoding (also exported on the debug state port)
//   - fixed I/O buffer register addresses and the run-start value
//   - saturating 16-bit increment used by the run counter
// ---------------------------------------------------------------------------
package sysarr_host_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_RUN     = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_RUN_ST = 3'd3,
        ST_GAP    = 3'd4,
        ST_POLL   = 3'd5,
        ST_RESP   = 3'd6
    } state_e;

    // I/O buffer register map
    localparam logic [15:0] ADR_STATUS    = 16'hFFF0;  // write 1 = start, bit0 read = running
    localparam logic [15:0] ADR_MAX_COUNT = 16'hFFF1;
    localparam logic [15:0] ADR_RUN_COUNT = 16'hFFF2;

    localparam logic [15:0] RUN_START_VAL = 16'h0001;
    localparam logic [15:0] ABORT_DATA    = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sysarr_host_seq_ibus_rd_timer.sv
// ---------------------------------------------------------------------------
// ibus_rd_timer
// Hold-and-sample ibus read engine shared by the plain read and the status
// poll. A start pulse launches a read: ren and radr are held stable for
// RD_LAT+1 cycles and ibus read data is sampled in the last of them.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start_i         launch a read at the next edge (only while idle)
//   abort_i         drop the strobe at the next edge, no sample taken
//   adr_i           address captured on start
//   rdata_i         ibus read data
//   ren_o, radr_o   registered read strobe and address (0 when idle)
//   done_o          high during the final (sampling) cycle of a read
//   data_o          read data: live bus data in the sampling cycle,
//                   otherwise the last sampled value
// ---------------------------------------------------------------------------
module ibus_rd_timer #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] rdata_i,
    output logic        ren_o,
    output logic [15:0] radr_o,
    output logic        done_o,
    output logic [15:0] data_o
);

    localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(RD_LAT);

    logic          ren_q;
    logic [15:0]   radr_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   sample_q;

    assign done_o = ren_q && (cnt_q == LAST);
    assign ren_o  = ren_q;
    assign radr_o = radr_q;
    // The caller consumes the sample in the same cycle it is taken, so the
    // live bus value is forwarded during the sampling cycle.
    assign data_o = done_o ? rdata_i : sample_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_q    <= 1'b0;
            radr_q   <= 16'h0000;
            cnt_q    <= '0;
            sample_q <= 16'h0000;
        end else if (abort_i) begin
            ren_q  <= 1'b0;
            radr_q <= 16'h0000;
            cnt_q  <= '0;
        end else if (start_i) begin
            ren_q  <= 1'b1;
            radr_q <= adr_i;
            cnt_q  <= '0;
        end else if (done_o) begin
            ren_q    <= 1'b0;
            radr_q   <= 16'h0000;
            cnt_q    <= '0;
            sample_q <= rdata_i;
        end else if (ren_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sysarr_host_seq.sv
// ---------------------------------------------------------------------------
// sysarr_host_seq
// Host command sequencer for the systolic array I/O buffer. Accepts one host
// command at a time (write, read, run, illegal), performs the ibus accesses,
// and returns a single response.
//
// A run writes the start value to the status register, then alternates a
// POLL_GAP idle gap with a status read until bit0 clears (response data =
// run cycle count) or the run counter reaches TIMEOUT (abort, data FFFF,
// err 1).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready is high only in IDLE; resp_valid is high only in
// RESP, and the response payload holds until resp_ready is seen.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/ready/op/adr/data   host command channel
//   resp_valid/ready/data/err     host response channel
//   ibus_ren, ibus_radr           ibus read strobe/address (from the timer)
//   ibus_wen, ibus_wadr, ibus_wdata  ibus write strobe/address/data
//   ibus_rdata                    ibus read data
//   busy                          high outside IDLE
//   dbg_state                     current sequencer state
// ---------------------------------------------------------------------------
module sysarr_host_seq
    import sysarr_host_seq_pkg::*;
#(
    parameter int          RD_LAT   = 2,
    parameter int          POLL_GAP = 4,
    parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_adr,
    input  logic [15:0] cmd_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        ibus_ren,
    output logic        ibus_wen,
    output logic [15:0] ibus_radr,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata,
    input  logic [15:0] ibus_rdata,
    output logic        busy,
    output state_e      dbg_state
);

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_e      state_q;
    logic        wen_q;
    logic [15:0] wadr_q;
    logic [15:0] wdata_q;
    logic        resp_valid_q;
    logic [15:0] resp_data_q;
    logic        resp_err_q;
    logic [15:0] run_cnt_q;
    logic [15:0] gap_cnt_q;

    logic        run_timeout;
    logic        gap_last;
    logic        rd_start;
    logic        rd_abort;
    logic [15:0] rd_adr;
    logic        rd_done;
    logic [15:0] rd_data;

    assign run_timeout = (run_cnt_q >= TIMEOUT);
    assign gap_last    = (gap_cnt_q == GAP_LAST);

    // A read is launched straight from IDLE for a read command, or from the
    // last GAP cycle for a status poll (unless the run has just timed out).
    assign rd_start = ((state_q == ST_IDLE) && cmd_valid && (cmd_op == OP_READ)) ||
                      ((state_q == ST_GAP) && !run_timeout && gap_last);
    assign rd_adr   = (state_q == ST_IDLE) ? cmd_adr : ADR_STATUS;
    // A timeout mid-poll drops the read strobe on the same edge we leave POLL.
    assign rd_abort = (state_q == ST_POLL) && run_timeout;

    ibus_rd_timer #(
        .RD_LAT (RD_LAT)
    ) u_rd_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (rd_start),
        .abort_i (rd_abort),
        .adr_i   (rd_adr),
        .rdata_i (ibus_rdata),
        .ren_o   (ibus_ren),
        .radr_o  (ibus_radr),
        .done_o  (rd_done),
        .data_o  (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wen_q        <= 1'b0;
            wadr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 16'h0000;
            resp_err_q   <= 1'b0;
            run_cnt_q    <= 16'h0000;
            gap_cnt_q    <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (op_e'(cmd_op))
                            OP_WRITE: begin
                                state_q <= ST_WR;
                                wen_q   <= 1'b1;
                                wadr_q  <= cmd_adr;
                                wdata_q <= cmd_data;
                            end
                            OP_READ: begin
                                state_q <= ST_RD;
                            end
                            OP_RUN: begin
                                state_q <= ST_RUN_ST;
                                wen_q   <= 1'b1;
                                wadr_q  <= ADR_STATUS;
                                wdata_q <= RUN_START_VAL;
                            end
                            default: begin
                                state_q      <= ST_RESP;
                                resp_valid_q <= 1'b1;
                                resp_data_q  <= 16'h0000;
                                resp_err_q   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_WR: begin
                    wen_q        <= 1'b0;
                    wadr_q       <= 16'h0000;
                    wdata_q      <= 16'h0000;
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= 16'h0000;
                    resp_err_q   <= 1'b0;
                end

                ST_RD: begin
                    if (rd_done) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= rd_data;
                        resp_err_q   <= 1'b0;
                    end
                end

                ST_RUN_ST: begin
                    wen_q     <= 1'b0;
                    wadr_q    <= 16'h0000;
                    wdata_q   <= 16'h0000;
                    run_cnt_q <= 16'h0000;
                    gap_cnt_q <= 16'h0000;
                    state_q   <= ST_GAP;
                end

                ST_GAP: begin
                    run_cnt_q <= sat_inc16(run_cnt_q);
                    if (run_timeout) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= ABORT_DATA;
                        resp_err_q   <= 1'b1;
                    end else if (gap_last) begin
                        state_q <= ST_POLL;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end

                ST_POLL: begin
                    run_cnt_q <= sat_inc16(run_cnt_q);
                    if (run_timeout) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= ABORT_DATA;
                        resp_err_q   <= 1'b1;
                    end else if (rd_done) begin
                        if (!rd_data[0]) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= run_cnt_q;
                            resp_err_q   <= 1'b0;
                        end else begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= 16'h0000;
                        end
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= 16'h0000;
                        resp_err_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held.
    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;
    assign ibus_wen   = wen_q;
    assign ibus_wadr  = wadr_q;
    assign ibus_wdata = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_sysarr_host_seq.sv
// ---------------------------------------------------------------------------
// tb_sysarr_host_seq
// Bench for the host sequencer with an I/O buffer model: a memory map for
// ordinary addresses and a status register whose bit0 is set by a start write
// and clears done_after cycles later. Run expectations are derived from the
// poll schedule (POLL_GAP idle cycles, then RD_LAT+1 read cycles) with the
// run counter reading 0 in the cycle after the start write.
// ---------------------------------------------------------------------------
module tb_sysarr_host_seq;
    import sysarr_host_seq_pkg::*;

    localparam int          RD_LAT   = 2;
    localparam int          POLL_GAP = 4;
    localparam logic [15:0] TMO      = 16'd100;
    localparam int          PER      = POLL_GAP + RD_LAT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_adr = 16'h0;
    logic [15:0] cmd_data = 16'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        ibus_ren, ibus_wen;
    logic [15:0] ibus_radr, ibus_wadr, ibus_wdata;
    logic [15:0] ibus_rdata = 16'h0;
    logic        busy;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    sysarr_host_seq #(
        .RD_LAT   (RD_LAT),
        .POLL_GAP (POLL_GAP),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_adr    (cmd_adr),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .ibus_ren   (ibus_ren),
        .ibus_wen   (ibus_wen),
        .ibus_radr  (ibus_radr),
        .ibus_wadr  (ibus_wadr),
        .ibus_wdata (ibus_wdata),
        .ibus_rdata (ibus_rdata),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- I/O buffer model and bus monitor ----------------
    int          cyc = 0;
    int          overlap_n = 0;
    int          idle_nz_n = 0;
    int          wen_n = 0;
    int          ren_n = 0;
    logic [15:0] wev_adr_q[$];
    logic [15:0] wev_dat_q[$];
    int          wev_cyc_q[$];
    int          ren_start_q[$];
    int          ren_len_q[$];
    int          run_len = 0;
    logic        ren_prev = 1'b0;
    logic        status = 1'b0;
    int          status_set_cyc = 0;
    int          done_after = 40;
    int          resp_rise_cyc = -1;
    logic        rv_prev = 1'b0;
    logic [15:0] mem[logic [15:0]];
    logic [15:0] ref_mem[logic [15:0]];

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (ibus_ren && ibus_wen) overlap_n++;
        if (!ibus_ren && !ibus_wen && (ibus_radr != 0 || ibus_wadr != 0 || ibus_wdata != 0))
            idle_nz_n++;
        if (ibus_wen) begin
            wen_n++;
            wev_adr_q.push_back(ibus_wadr);
            wev_dat_q.push_back(ibus_wdata);
            wev_cyc_q.push_back(cyc);
            if (ibus_wadr == 16'hFFF0) begin
                if (ibus_wdata[0]) begin
                    status = 1'b1;
                    status_set_cyc = cyc;
                end
            end else begin
                mem[ibus_wadr] = ibus_wdata;
            end
        end
        if (ibus_ren) begin
            ren_n++;
            if (!ren_prev) begin
                ren_start_q.push_back(cyc);
                run_len = 0;
            end
            run_len++;
        end else if (ren_prev) begin
            ren_len_q.push_back(run_len);
        end
        ren_prev = ibus_ren;
        if (status && (cyc - status_set_cyc >= done_after)) status = 1'b0;
        if (resp_valid && !rv_prev) resp_rise_cyc = cyc;
        rv_prev = resp_valid;
        if (ibus_ren)
            ibus_rdata = (ibus_radr == 16'hFFF0) ? {15'd0, status} :
                         (mem.exists(ibus_radr) ? mem[ibus_radr] : dflt(ibus_radr));
        else
            ibus_rdata = 16'h0;
    end

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];   // {err, data}

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic clear_mon();
        wev_adr_q.delete();
        wev_dat_q.delete();
        wev_cyc_q.delete();
        ren_start_q.delete();
        ren_len_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [15:0] adr, input logic [15:0] dat);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_adr   = adr;
        cmd_data  = dat;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%0b expected 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_adr   = 16'h0;
        cmd_data  = 16'h0;
    endtask

    // Waits for a response, holds resp_ready low for delay cycles, completes
    // the handshake and compares the payload with the scoreboard head.
    task automatic get_resp(input int delay, input string name);
        int n = 0;
        logic [16:0] exp;
        logic [16:0] got;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1DEAD;
        while (!resp_valid && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!resp_valid) begin
            errors++;
            $display("FAIL %s_resp_timeout: resp_valid=%0b expected 1 within 1000 cycles", name, resp_valid);
        end else begin
            got = {resp_err, resp_data};
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_resp: err/data=%0b/%h expected %0b/%h", name, got[16], got[15:0], exp[16], exp[15:0]);
            end
            repeat (delay) begin
                @(posedge clk); #1;
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            checks++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_return_idle: cmd_ready=%0b busy=%0b expected 1/0", name, cmd_ready, busy);
            end
        end
    endtask

    // Number of ibus read cycles a run schedule performs up to and including
    // run-relative offset last_off (offset 0 = start write cycle).
    function automatic int ren_cycles_upto(input int last_off);
        int c = 0;
        for (int o = 1; o <= last_off; o++)
            if (((o - 1) % PER) >= POLL_GAP) c++;
        return c;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_ready, resp_valid, resp_data, resp_err, ibus_ren, ibus_wen, ibus_radr,
             ibus_wadr, ibus_wdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cmd_ready=%0b resp_valid=%0b ren=%0b wen=%0b busy=%0b expected all 0",
                     cmd_ready, resp_valid, ibus_ren, ibus_wen, busy);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%0b busy=%0b expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write(input logic [15:0] adr, input logic [15:0] dat, input string name);
        int w0, r0;
        clear_mon();
        w0 = wen_n;
        r0 = ren_n;
        ref_mem[adr] = dat;
        exp_q.push_back({1'b0, 16'h0000});
        send_cmd(2'd0, adr, dat);
        get_resp($urandom_range(0, 3), name);
        checks++;
        if (wen_n - w0 != 1 || ren_n != r0) begin
            errors++;
            $display("FAIL %s_strobes: wen cycles=%0d ren cycles=%0d expected 1/0", name, wen_n - w0, ren_n - r0);
        end
        checks++;
        if (wev_adr_q.size() != 1) begin
            errors++;
            $display("FAIL %s_event: write events=%0d expected 1", name, wev_adr_q.size());
        end else if (wev_adr_q[0] !== adr || wev_dat_q[0] !== dat) begin
            errors++;
            $display("FAIL %s_event: wadr/wdata=%h/%h expected %h/%h", name, wev_adr_q[0], wev_dat_q[0], adr, dat);
        end
    endtask

    task automatic test_read(input logic [15:0] adr, input string name);
        int w0;
        clear_mon();
        w0 = wen_n;
        exp_q.push_back({1'b0, ref_rd(adr)});
        send_cmd(2'd1, adr, 16'h0);
        get_resp($urandom_range(0, 3), name);
        checks++;
        if (ren_len_q.size() != 1 || ren_start_q.size() != 1 || wen_n != w0) begin
            errors++;
            $display("FAIL %s_strobes: ren bursts=%0d wen cycles=%0d expected 1/0", name, ren_len_q.size(), wen_n - w0);
        end else if (ren_len_q[0] != RD_LAT + 1) begin
            errors++;
            $display("FAIL %s_ren_len: ren high %0d cycles expected %0d", name, ren_len_q[0], RD_LAT + 1);
        end
    endtask

    task automatic test_illegal_hold();
        int w0, r0;
        int n = 0;
        w0 = wen_n;
        r0 = ren_n;
        send_cmd(2'd3, 16'h1111, 16'h2222);
        while (!resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 16'h0000) begin
                errors++;
                $display("FAIL illegal_hold_%0d: valid/err/data=%0b/%0b/%h expected 1/1/0000", i, resp_valid, resp_err, resp_data);
            end
            @(posedge clk); #1;
        end
        exp_q.push_back({1'b1, 16'h0000});
        get_resp(0, "illegal");
        checks++;
        if (wen_n != w0 || ren_n != r0) begin
            errors++;
            $display("FAIL illegal_strobes: wen=%0d ren=%0d expected 0/0", wen_n - w0, ren_n - r0);
        end
    endtask

    task automatic test_random(input int count);
        int r;
        logic [15:0] a, d;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            a = 16'($urandom_range(0, 16'h00FF));
            d = 16'($urandom);
            if (r < 4)      test_write(a, d, "rand_wr");
            else if (r < 8) test_read(a, "rand_rd");
            else            test_illegal_hold();
        end
    endtask

    task automatic test_run();
        int k = 0;
        int samp, s, w0;
        done_after = 40;
        samp = 1 + POLL_GAP + RD_LAT;
        while (samp < done_after) begin
            k++;
            samp += PER;
        end
        clear_mon();
        w0 = wen_n;
        exp_q.push_back({1'b0, 16'(samp - 1)});
        send_cmd(2'd2, 16'h0, 16'h0);
        get_resp(1, "run");
        checks++;
        if (wen_n - w0 != 1 || wev_adr_q.size() != 1) begin
            errors++;
            $display("FAIL run_start_write: writes=%0d expected 1", wen_n - w0);
        end else if (wev_adr_q[0] !== 16'hFFF0 || wev_dat_q[0] !== 16'h0001) begin
            errors++;
            $display("FAIL run_start_write: wadr/wdata=%h/%h expected fff0/0001", wev_adr_q[0], wev_dat_q[0]);
        end
        s = (wev_cyc_q.size() > 0) ? wev_cyc_q[0] : 0;
        checks++;
        if (ren_start_q.size() != k + 1) begin
            errors++;
            $display("FAIL run_poll_count: polls=%0d expected %0d", ren_start_q.size(), k + 1);
        end else begin
            for (int i = 0; i <= k; i++) begin
                checks++;
                if (ren_start_q[i] != s + 1 + POLL_GAP + i * PER || ren_len_q[i] != RD_LAT + 1) begin
                    errors++;
                    $display("FAIL run_poll_%0d: start offset %0d len %0d expected %0d/%0d", i,
                             ren_start_q[i] - s, ren_len_q[i], 1 + POLL_GAP + i * PER, RD_LAT + 1);
                end
            end
        end
        checks++;
        if (resp_rise_cyc != s + samp + 1) begin
            errors++;
            $display("FAIL run_resp_time: resp offset %0d expected %0d", resp_rise_cyc - s, samp + 1);
        end
    endtask

    task automatic test_timeout();
        int s, w0, r0, exp_ren;
        done_after = 1000000;
        clear_mon();
        w0 = wen_n;
        r0 = ren_n;
        exp_ren = ren_cycles_upto(1 + int'(TMO));
        exp_q.push_back({1'b1, 16'hFFFF});
        send_cmd(2'd2, 16'h0, 16'h0);
        get_resp(6, "timeout");
        repeat (10) @(posedge clk);
        #1;
        s = (wev_cyc_q.size() > 0) ? wev_cyc_q[0] : 0;
        checks++;
        if (resp_rise_cyc != s + int'(TMO) + 2) begin
            errors++;
            $display("FAIL timeout_time: resp offset %0d expected %0d", resp_rise_cyc - s, int'(TMO) + 2);
        end
        checks++;
        if (wen_n - w0 != 1 || ren_n - r0 != exp_ren) begin
            errors++;
            $display("FAIL timeout_bus_activity: wen=%0d ren=%0d expected 1/%0d", wen_n - w0, ren_n - r0, exp_ren);
        end
    endtask

    task automatic test_back_to_back();
        int rise[$];
        int n = 0;
        int w0, r0;
        w0 = wen_n;
        r0 = ren_n;
        resp_ready = 1'b1;
        cmd_valid  = 1'b1;
        cmd_op     = 2'd3;
        cmd_adr    = 16'h0;
        cmd_data   = 16'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                rise.push_back(i);
                checks++;
                if (resp_err !== 1'b1 || resp_data !== 16'h0) begin
                    errors++;
                    $display("FAIL b2b_payload: err/data=%0b/%h expected 1/0000", resp_err, resp_data);
                end
            end
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        while (busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        resp_ready = 1'b0;
        checks++;
        if (rise.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: responses=%0d expected 6", rise.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (rise[i] - rise[i-1] != 2) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: spacing %0d expected 2", i, rise[i] - rise[i-1]);
                end
            end
        end
        checks++;
        if (wen_n != w0 || ren_n != r0) begin
            errors++;
            $display("FAIL b2b_strobes: wen=%0d ren=%0d expected 0/0", wen_n - w0, ren_n - r0);
        end
    endtask

    task automatic test_reset_mid_poll();
        int n = 0;
        int seen = 0;
        done_after = 1000000;
        send_cmd(2'd2, 16'h0, 16'h0);
        while (!ibus_ren && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ibus_ren !== 1'b1) begin
            errors++;
            $display("FAIL rst_poll_reach: ren=%0b expected 1", ibus_ren);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ibus_ren !== 1'b0 || ibus_wen !== 1'b0 || ibus_radr !== 16'h0) begin
            errors++;
            $display("FAIL rst_strobes: ren=%0b wen=%0b radr=%h expected 0/0/0000", ibus_ren, ibus_wen, ibus_radr);
        end
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: resp_valid=%0b busy=%0b cmd_ready=%0b expected 0/0/0", resp_valid, busy, cmd_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (resp_valid || ibus_ren || ibus_wen || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_no_resume: %0d active cycles after reset expected 0", seen);
        end
        test_write(16'h0042, 16'($urandom), "post_rst_wr");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ref_mem[16'h8003] = 16'hBEEF;
        mem[16'h8003]     = 16'hBEEF;
        test_reset();
        test_write(16'h0005, 16'h1234, "wr_0005");
        test_read(16'h8003, "rd_8003");
        test_read(16'h0005, "rd_0005");
        test_random(24);
        test_run();
        test_timeout();
        test_illegal_hold();
        test_back_to_back();
        test_reset_mid_poll();
        checks++;
        if (overlap_n != 0 || idle_nz_n != 0) begin
            errors++;
            $display("FAIL bus_rules: ren&wen cycles=%0d nonzero idle bus cycles=%0d expected 0/0", overlap_n, idle_nz_n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysarr_host_seq.md
SYSARR_HOST_SEQ -- requirements
Module: sysarr_host_seq

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, cycles from read issue to ibus_rdata sample.
REQ-002 SHALL have parameter POLL_GAP, default 4, idle cycles between status polls (minimum 1).
REQ-003 SHALL have parameter TIMEOUT, default 16'hFFFF, maximum run cycles before abort.
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: cmd_valid  input  1  host command present.
REQ-007 Port: cmd_ready  output  1  command accepted when both valid and ready are high.
REQ-008 Port: cmd_op  input  2  0=write, 1=read, 2=run, 3=illegal.
REQ-009 Port: cmd_adr / cmd_data  input  16/16  target address and write data.
REQ-010 Port: resp_valid  output  1; resp_ready  input  1  response handshake.
REQ-011 Port: resp_data  output  16; resp_err  output  1  response payload and error flag.
REQ-012 Port: ibus_ren, ibus_wen  output  1  ibus read and write strobes to the I/O buffer block.
REQ-013 Port: ibus_radr, ibus_wadr, ibus_wdata  output  16  ibus address and data.
REQ-014 Port: ibus_rdata  input  16  ibus read data.
REQ-015 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-016 States SHALL be IDLE, WR, RD, RUN_ST, GAP, POLL, RESP; cmd_ready SHALL equal (state==IDLE).
REQ-017 A write SHALL drive ibus_wen=1 with wadr=cmd_adr and wdata=cmd_data for exactly one cycle, then go to RESP with data 0 and err 0.
REQ-018 A read SHALL hold ibus_ren=1 and radr=cmd_adr stable for RD_LAT+1 cycles, sample ibus_rdata in the last of those cycles, then go to RESP.
REQ-019 A run SHALL write 16'h0001 to 16'hFFF0 for one cycle, clear the run counter to 0, then enter GAP.
REQ-020 GAP SHALL wait POLL_GAP cycles, then enter POLL.
REQ-021 POLL SHALL read 16'hFFF0 using the REQ-018 timing.
  - sampled bit0=0: go to RESP, data = run counter, err 0.
  - sampled bit0=1: return to GAP.
REQ-022 The run counter SHALL increment every cycle from the cycle after the start write until RESP, saturating at 16'hFFFF.
REQ-023 When the run counter reaches TIMEOUT before completion, the block SHALL abort to RESP with data 16'hFFFF and err 1, and SHALL NOT issue further bus accesses.
REQ-024 Illegal op SHALL go directly to RESP with data 0 and err 1, with no ibus strobe.
REQ-025 In RESP, resp_valid SHALL be 1 and resp_data/resp_err SHALL hold until resp_ready; the block SHALL return to IDLE in the cycle after the handshake.
REQ-026 ibus_ren and ibus_wen SHALL never be high in the same cycle.
REQ-027 When neither strobe is active, addresses and wdata SHALL be 0.
REQ-028 A new command SHALL be accepted no earlier than the cycle after the return to IDLE, giving two cycles minimum between responses.

Reset
REQ-029 rst SHALL immediately force IDLE and drive all outputs to 0, including the run counter and sample register; cmd_ready SHALL be 1 after reset release.
REQ-030 Reset mid-run SHALL drop all strobes the same cycle, issue no response, and not restore the in-flight command.

Structure
REQ-031 The shared package SHALL hold:
  - op codes;
  - state encoding;
  - addresses 16'hFFF0 (start/status), 16'hFFF1 (max count), 16'hFFF2 (run count).
REQ-032 A single sub-module, ibus_rd_timer, SHALL implement the RD_LAT hold-and-sample read used by RD and POLL.

Verification
REQ-033 Write op adr 16'h0005 data 16'h1234 -> one-cycle wen with wadr 0005, wdata 1234; resp data 0, err 0.
REQ-034 Read op adr 16'h8003 with memory model returning 16'hBEEF at RD_LAT=2 -> ren high 3 cycles; resp data BEEF.
REQ-035 Run op with status model clearing bit0 40 cycles after start (POLL_GAP=4) -> exactly one start write; polls every 7 cycles; resp err 0; data is the count at completion (within one poll period of 40).
REQ-036 Run op with TIMEOUT=100 and status stuck at 1 -> resp data FFFF, err 1, at counter 100; no ibus activity afterward.
REQ-037 Illegal op 3, and resp_ready held low for 5 cycles -> response stable for all 5 cycles; err 1; no strobes.
REQ-038 rst asserted during POLL -> strobes 0 in the same cycle; no response; next write op completes normally.
